// File: rtl/cache_ctrl_if.sv
`default_nettype none
// ==== cache_ctrl_if : CPU, cache-array and main-memory signal bundle for cache_ctrl. Rev 1.0 ====
interface cache_ctrl_if;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        Rd;
  logic        Wr;
  logic [15:0] DataOut;
  logic        Done;
  logic        Stall;
  logic        CacheHit;
  logic        err;

  logic        c_enable;
  logic        c_comp;
  logic        c_write;
  logic        c_valid_in;
  logic [4:0]  c_tag;
  logic [7:0]  c_index;
  logic [2:0]  c_offset;
  logic [15:0] c_data_in;
  logic [4:0]  c_tag_out;
  logic [15:0] c_data_out;
  logic        c_hit;
  logic        c_dirty;
  logic        c_valid;

  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_wr;
  logic        mem_rd;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;

  modport slave (
    input  Addr, DataIn, Rd, Wr,
    output DataOut, Done, Stall, CacheHit, err,
    output c_enable, c_comp, c_write, c_valid_in, c_tag, c_index, c_offset, c_data_in,
    input  c_tag_out, c_data_out, c_hit, c_dirty, c_valid,
    output mem_addr, mem_wdata, mem_wr, mem_rd,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport master (
    output Addr, DataIn, Rd, Wr,
    input  DataOut, Done, Stall, CacheHit, err,
    input  c_enable, c_comp, c_write, c_valid_in, c_tag, c_index, c_offset, c_data_in,
    output c_tag_out, c_data_out, c_hit, c_dirty, c_valid,
    input  mem_addr, mem_wdata, mem_wr, mem_rd,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/cache_ctrl.sv
`default_nettype none
// ==== cache_ctrl : direct-mapped write-back/write-allocate cache controller. Rev 1.0 ====
// ==== Optional hit/miss statistics built only when CACHE_CTRL_STATS_EN is defined.     ====
module cache_ctrl #(
  parameter int ID = 0
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  cache_ctrl_if.slave bus,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB     = 2'd1,
    FILL   = 2'd2,
    REPLAY = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] addr_q, data_q;
  logic        wr_q;
  logic [4:0]  victim_q;
  logic [1:0]  wb_cnt, ret_cnt;
  logic [2:0]  iss_cnt;
  logic        latch_req, wb_adv, iss_adv, ret_adv;

  wire [31:0] unused_id = 32'(ID);

  always_comb begin
    state_nxt      = state;
    latch_req      = 1'b0;
    wb_adv         = 1'b0;
    iss_adv        = 1'b0;
    ret_adv        = 1'b0;
    bus.DataOut    = '0;
    bus.Done       = 1'b0;
    bus.CacheHit   = 1'b0;
    bus.err        = 1'b0;
    bus.Stall      = (state != IDLE);
    bus.c_enable   = 1'b0;
    bus.c_comp     = 1'b0;
    bus.c_write    = 1'b0;
    bus.c_valid_in = 1'b0;
    bus.c_tag      = '0;
    bus.c_index    = '0;
    bus.c_offset   = '0;
    bus.c_data_in  = '0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.mem_wr     = 1'b0;
    bus.mem_rd     = 1'b0;

    case (state)
      IDLE: begin
        if (rst_n && (bus.Rd || bus.Wr)) begin
          if ((bus.Rd && bus.Wr) || bus.Addr[0]) begin
            bus.Done = 1'b1;
            bus.err  = 1'b1;
          end else begin
            latch_req     = 1'b1;
            bus.c_enable  = 1'b1;
            bus.c_comp    = 1'b1;
            bus.c_write   = bus.Wr;
            bus.c_tag     = bus.Addr[15:11];
            bus.c_index   = bus.Addr[10:3];
            bus.c_offset  = bus.Addr[2:0];
            bus.c_data_in = bus.DataIn;
            if (bus.c_hit && bus.c_valid) begin
              bus.Done     = 1'b1;
              bus.CacheHit = 1'b1;
              if (bus.Rd) bus.DataOut = bus.c_data_out;
            end else begin
              state_nxt = (bus.c_valid && bus.c_dirty) ? WB : FILL;
            end
          end
        end
      end
      WB: begin
        bus.c_enable  = 1'b1;
        bus.c_tag     = victim_q;
        bus.c_index   = addr_q[10:3];
        bus.c_offset  = {wb_cnt, 1'b0};
        bus.mem_wr    = 1'b1;
        bus.mem_addr  = {victim_q, addr_q[10:3], wb_cnt, 1'b0};
        bus.mem_wdata = bus.c_data_out;
        if (bus.mem_ready) begin
          wb_adv = 1'b1;
          if (wb_cnt == 2'd3) state_nxt = FILL;
        end
      end
      FILL: begin
        if (!iss_cnt[2]) begin
          bus.mem_rd   = 1'b1;
          bus.mem_addr = {addr_q[15:3], iss_cnt[1:0], 1'b0};
          iss_adv      = bus.mem_ready;
        end
        // A return is only accepted against a read this fill has actually issued.
        if (bus.mem_rvalid && ({1'b0, ret_cnt} < iss_cnt)) begin
          ret_adv        = 1'b1;
          bus.c_enable   = 1'b1;
          bus.c_write    = 1'b1;
          bus.c_valid_in = 1'b1;
          bus.c_tag      = addr_q[15:11];
          bus.c_index    = addr_q[10:3];
          bus.c_offset   = {ret_cnt, 1'b0};
          bus.c_data_in  = bus.mem_rdata;
          if (ret_cnt == 2'd3) state_nxt = REPLAY;
        end
      end
      REPLAY: begin
        bus.c_enable  = 1'b1;
        bus.c_comp    = 1'b1;
        bus.c_write   = wr_q;
        bus.c_tag     = addr_q[15:11];
        bus.c_index   = addr_q[10:3];
        bus.c_offset  = addr_q[2:0];
        bus.c_data_in = data_q;
        bus.Done      = 1'b1;
        if (!wr_q) bus.DataOut = bus.c_data_out;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      wr_q     <= 1'b0;
      victim_q <= '0;
      wb_cnt   <= '0;
      iss_cnt  <= '0;
      ret_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (latch_req) begin
        addr_q  <= bus.Addr;
        data_q  <= bus.DataIn;
        wr_q    <= bus.Wr;
        wb_cnt  <= '0;
        iss_cnt <= '0;
        ret_cnt <= '0;
        if (state_nxt == WB) victim_q <= bus.c_tag_out;
      end
      if (wb_adv)  wb_cnt  <= wb_cnt + 2'd1;
      if (iss_adv) iss_cnt <= iss_cnt + 3'd1;
      if (ret_adv) ret_cnt <= ret_cnt + 2'd1;
    end
  end

`ifdef CACHE_CTRL_STATS_EN
  logic [15:0] hit_q, miss_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (bus.Done && bus.CacheHit && (hit_q != 16'hFFFF))
        hit_q <= hit_q + 16'd1;
      if ((state == IDLE) && (state_nxt != IDLE) && (miss_q != 16'hFFFF))
        miss_q <= miss_q + 16'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif
endmodule
`default_nettype wire
